// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants a single synchronous data memory to either the CPU
// or the DMA engine, with CPU priority from idle and a burst limit that forces
// a handover when the other requester is waiting.
module mem_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_last,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic          cpu_rvalid,
    output logic          dma_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    arb_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_DMA = 2'b10
    } state_t;

    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] burst_cnt;
    logic       cpu_xfer;
    logic       dma_xfer;
    logic       xfer;
    logic       burst_full;

    // A transfer is a cycle where the owner is requesting while granted.
    assign cpu_xfer   = cpu_req & (state == GNT_CPU);
    assign dma_xfer   = dma_req & (state == GNT_DMA);
    assign xfer       = cpu_xfer | dma_xfer;
    // True when this cycle's transfer leaves the counter at the burst limit
    // (including when it is already saturated there).
    assign burst_full = xfer & (burst_cnt >= BURST_LAST);

    // Read data is shared; the rvalid strobes say who it belongs to.
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Burst counter: restarts on every ownership change, saturates at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= 8'd0;
        end else if (next_state != state) begin
            burst_cnt <= 8'd0;
        end else if (xfer && (burst_cnt < BURST_MAX)) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end

    // Next-state decision; the leaving owner's transfer still completes this cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    next_state = GNT_CPU;
                end else if (dma_req) begin
                    next_state = GNT_DMA;
                end
            end
            GNT_CPU: begin
                if (!cpu_req) begin
                    next_state = dma_req ? GNT_DMA : IDLE;
                end else if (burst_full && dma_req) begin
                    next_state = GNT_DMA;
                end
            end
            GNT_DMA: begin
                if (!dma_req) begin
                    next_state = cpu_req ? GNT_CPU : IDLE;
                end else if (dma_last) begin
                    next_state = cpu_req ? GNT_CPU : IDLE;
                end else if (burst_full && cpu_req) begin
                    next_state = GNT_CPU;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grants and memory port follow the current owner combinationally.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        arb_state = state;
        mem_en    = xfer;
        mem_we    = (cpu_xfer & cpu_we) | (dma_xfer & dma_we);
        unique case (state)
            GNT_CPU: begin
                cpu_gnt   = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            GNT_DMA: begin
                dma_gnt   = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: begin
                cpu_gnt = 1'b0;
            end
        endcase
    end

    // Read strobes mark the cycle the memory returns data for a read transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_xfer & ~cpu_we;
            dma_rvalid <= dma_xfer & ~dma_we;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, consecutive transfers an owner keeps while the other requester waits (legal 2..255).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_req, cpu_we  in  1 each  CPU request and write enable.
REQ-007 SHALL have ports cpu_addr  in  AW, cpu_wdata  in  DW  CPU address and write data.
REQ-008 SHALL have ports dma_req, dma_we, dma_last  in  1 each  DMA request, write enable, final beat of DMA block.
REQ-009 SHALL have ports dma_addr  in  AW, dma_wdata  in  DW  DMA address and write data.
REQ-010 SHALL have ports cpu_gnt, dma_gnt  out  1 each  registered grants.
REQ-011 SHALL have ports cpu_rvalid, dma_rvalid  out  1 each  read data valid strobes.
REQ-012 SHALL have ports cpu_rdata, dma_rdata  out  DW  both driven directly from mem_rdata.
REQ-013 SHALL have ports mem_en, mem_we  out  1, mem_addr  out  AW, mem_wdata  out  DW  to synchronous data memory.
REQ-014 SHALL have port mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-015 SHALL have port arb_state  out  2  00 IDLE, 01 GNT_CPU, 10 GNT_DMA.

Function
REQ-016 SHALL implement FSM states IDLE, GNT_CPU, GNT_DMA; cpu_gnt=(state==GNT_CPU), dma_gnt=(state==GNT_DMA); both never high together.
REQ-017 SHALL define a transfer as a cycle with x_req & x_gnt; at most one transfer per cycle.
REQ-018 SHALL drive mem_en=transfer, mem_we=owner_we & transfer, mem_addr/mem_wdata muxed combinationally from current owner; mem_addr/mem_wdata=0 in IDLE.
REQ-019 SHALL, from IDLE: cpu_req -> GNT_CPU (CPU wins simultaneous requests); else dma_req -> GNT_DMA; else stay; grant latency one cycle.
REQ-020 SHALL keep burst counter (8 bits): cleared on every state change, +1 per transfer, saturating at MAX_BURST.
REQ-021 SHALL, in GNT_CPU: if cpu_req=0 -> GNT_DMA when dma_req else IDLE; if transfer makes count reach MAX_BURST and dma_req=1 -> GNT_DMA; else stay.
REQ-022 SHALL, in GNT_DMA: if dma_req=0 -> GNT_CPU when cpu_req else IDLE; if transfer with dma_last=1 -> GNT_CPU when cpu_req else IDLE; if transfer makes count reach MAX_BURST and cpu_req=1 -> GNT_CPU; else stay.
REQ-023 SHALL hand over with zero bubble: the leaving owner's transfer in the decision cycle completes; new owner granted next cycle.
REQ-024 SHALL continue granting indefinitely past MAX_BURST while the other requester is idle (counter saturated).
REQ-025 SHALL register x_rvalid = 1 in cycle after a read transfer by that requester, independent of any ownership change in between.

Reset
REQ-026 SHALL, on reset=0, immediately force state IDLE, counter 0, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we to 0, arb_state=00.
REQ-027 SHALL discard any in-flight read strobe when reset asserts mid-transfer; no rvalid after reset release without a new transfer.
REQ-028 SHALL leave IDLE no earlier than the first rising edge after reset deassertion.

Verification
REQ-029 SHALL cover: cpu_req and dma_req rise same cycle from IDLE -> cpu_gnt=1 next cycle, dma_gnt=0.
REQ-030 SHALL cover: CPU reads addr 0x10 -> mem_en=1, mem_we=0, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata.
REQ-031 SHALL cover: MAX_BURST=4, CPU holds cpu_req continuously, dma_req high -> exactly 4 CPU transfers, then dma_gnt=1 the following cycle.
REQ-032 SHALL cover: DMA burst of 3 writes with dma_last on third, cpu_req low -> 3 mem_we pulses, then IDLE, arb_state=00.
REQ-033 SHALL cover: DMA read then immediate handoff to CPU -> dma_rvalid=1 (not cpu_rvalid) in the cycle cpu_gnt first asserts.
REQ-034 SHALL cover: reset pulled low during GNT_DMA with pending read -> all grants/strobes 0 asynchronously, arb_state=00, no dma_rvalid after release.
